// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module   : id_ex_stage_pkg
// Brief    : Shared ALU-op classes, opcode constants and control bundle for ID/EX
// Revision : 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

    localparam logic [1:0] ALUOP_LOAD_STORE = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH     = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE      = 2'b10;

    // opcode[6:2]; the low two bits are always 2'b11 in RV32I
    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    localparam int CTRL_W = 8;

    typedef struct packed {
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    // Invalid slots must never carry side-effecting control into EX.
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic v);
        return v ? c : '0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
// ============================================================================
// Module   : hazard_detect
// Brief    : Load-use hazard detection against the EX slot; flush suppresses stall
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       flush,
    output logic       hz,
    output logic       stall
);

    logic w_match;

    // x0 is hardwired zero, so a load targeting it has no consumer to wait for
    assign w_match = (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign hz      = id_valid & ex_valid & ex_memread & w_match;
    assign stall   = hz & ~flush;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with load-use bubble insertion and counter
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_memtoreg,
    input  logic             id_memwrite,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic [1:0]       id_aluop,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic [1:0]       ex_aluop,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             r_valid;
    ctrl_t            r_ctrl;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [2:0]       r_funct3;
    logic             r_funct7b5;
    logic [CNT_W-1:0] r_bubble_cnt;

    ctrl_t            w_id_ctrl;
    logic             w_hz;

    assign w_id_ctrl = '{branch:   id_branch,
                         memread:  id_memread,
                         memtoreg: id_memtoreg,
                         memwrite: id_memwrite,
                         alusrc:   id_alusrc,
                         regwrite: id_regwrite,
                         aluop:    id_aluop};

    hazard_detect u_hazard_detect (
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .ex_valid   (r_valid),
        .ex_memread (r_ctrl.memread),
        .ex_rd      (r_rd),
        .flush      (flush),
        .hz         (w_hz),
        .stall      (stall)
    );

    // Bubbles leave datapath fields stale; only valid and control are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_funct3     <= '0;
            r_funct7b5   <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_hz) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (r_bubble_cnt != {CNT_W{1'b1}}) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else begin
            r_valid    <= id_valid;
            r_ctrl     <= ctrl_gate(w_id_ctrl, id_valid);
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_funct3   <= id_funct3;
            r_funct7b5 <= id_funct7b5;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_funct3   = r_funct3;
    assign ex_funct7b5 = r_funct7b5;
    assign ex_branch   = r_ctrl.branch;
    assign ex_memread  = r_ctrl.memread;
    assign ex_memtoreg = r_ctrl.memtoreg;
    assign ex_memwrite = r_ctrl.memwrite;
    assign ex_alusrc   = r_ctrl.alusrc;
    assign ex_regwrite = r_ctrl.regwrite;
    assign ex_aluop    = r_ctrl.aluop;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed + randomized check of id_ex_stage against a slot-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic        br, mr, mtr, mw, as, rw;
        logic [1:0]  aop;
    } slot_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [2:0]       id_funct3;
    logic             id_funct7b5;
    logic             id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
    logic [1:0]       id_aluop;
    logic             flush;
    logic             stall;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_funct7b5;
    logic             ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]       ex_aluop;
    logic [CNT_W-1:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    slot_t       m;       // expected EX slot contents
    int unsigned m_cnt;   // expected bubble count

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .id_branch(id_branch), .id_memread(id_memread),
        .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite), .id_alusrc(id_alusrc),
        .id_regwrite(id_regwrite), .id_aluop(id_aluop), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
        .ex_aluop(ex_aluop), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{valid: 1'b0, pc: '0, rs1d: '0, rs2d: '0, imm: '0, rs1: '0, rs2: '0, rd: '0,
              f3: '0, f7: 1'b0, br: 1'b0, mr: 1'b0, mtr: 1'b0, mw: 1'b0, as: 1'b0,
              rw: 1'b0, aop: 2'b00};
        return s;
    endfunction

    function automatic slot_t rtype(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        slot_t s = empty_slot();
        s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        s.pc = $urandom; s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom;
        s.rw = 1'b1; s.aop = ALUOP_RTYPE;
        return s;
    endfunction

    function automatic slot_t load(input logic [4:0] rd, input logic [4:0] rs1);
        slot_t s = empty_slot();
        s.valid = 1'b1; s.rd = rd; s.rs1 = rs1; s.rs2 = 5'($urandom_range(0, 31));
        s.pc = $urandom; s.rs1d = $urandom; s.f3 = 3'b010;
        s.mr = 1'b1; s.mtr = 1'b1; s.as = 1'b1; s.rw = 1'b1; s.aop = ALUOP_LOAD_STORE;
        return s;
    endfunction

    function automatic slot_t store(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        slot_t s = empty_slot();
        s.valid = 1'b1; s.rs1 = rs1; s.rs2 = rs2; s.imm = imm; s.f3 = 3'b010;
        s.pc = $urandom; s.rs1d = $urandom; s.rs2d = $urandom;
        s.mw = 1'b1; s.as = 1'b1; s.aop = ALUOP_LOAD_STORE;
        return s;
    endfunction

    function automatic slot_t rand_slot();
        slot_t s;
        case ($urandom_range(0, 3))
            0: s = rtype(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            1: s = load(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            2: s = store(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
            default: begin
                s = store(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom);
                s.mw = 1'b0; s.as = 1'b0; s.br = 1'b1; s.aop = ALUOP_BRANCH;
            end
        endcase
        s.f3  = 3'($urandom);
        s.f7  = 1'($urandom);
        s.rd  = 5'($urandom_range(0, 3));
        s.valid = ($urandom_range(0, 7) != 0);
        return s;
    endfunction

    task automatic drive(input slot_t s);
        id_valid = s.valid; id_pc = s.pc; id_rs1_data = s.rs1d; id_rs2_data = s.rs2d;
        id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_funct3 = s.f3; id_funct7b5 = s.f7;
        id_branch = s.br; id_memread = s.mr; id_memtoreg = s.mtr; id_memwrite = s.mw;
        id_alusrc = s.as; id_regwrite = s.rw; id_aluop = s.aop;
    endtask

    task automatic check_ex(input bit with_dp);
        chk("ex_valid",    ex_valid,    m.valid);
        chk("ex_branch",   ex_branch,   m.br);
        chk("ex_memread",  ex_memread,  m.mr);
        chk("ex_memtoreg", ex_memtoreg, m.mtr);
        chk("ex_memwrite", ex_memwrite, m.mw);
        chk("ex_alusrc",   ex_alusrc,   m.as);
        chk("ex_regwrite", ex_regwrite, m.rw);
        chk("ex_aluop",    ex_aluop,    m.aop);
        chk("bubble_cnt",  bubble_cnt,  m_cnt);
        if (with_dp || m.valid) begin
            chk("ex_pc",       ex_pc,       m.pc);
            chk("ex_rs1_data", ex_rs1_data, m.rs1d);
            chk("ex_rs2_data", ex_rs2_data, m.rs2d);
            chk("ex_imm",      ex_imm,      m.imm);
            chk("ex_rs1",      ex_rs1,      m.rs1);
            chk("ex_rs2",      ex_rs2,      m.rs2);
            chk("ex_rd",       ex_rd,       m.rd);
            chk("ex_funct3",   ex_funct3,   m.f3);
            chk("ex_funct7b5", ex_funct7b5, m.f7);
        end
    endtask

    // Called just after a falling edge: apply ID, check stall, clock, check EX.
    task automatic step(input slot_t s, input logic fl, output logic exp_stall);
        logic hz;
        drive(s);
        flush = fl;
        #1;
        hz = s.valid && m.valid && m.mr && (m.rd != 0) && (m.rd == s.rs1 || m.rd == s.rs2);
        exp_stall = hz && !fl;
        chk("stall", stall, exp_stall);
        @(posedge clk);
        if (fl || hz) begin
            m.valid = 1'b0; m.br = 0; m.mr = 0; m.mtr = 0; m.mw = 0; m.as = 0; m.rw = 0; m.aop = 2'b00;
            if (!fl && m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m = s;
            if (!s.valid) begin
                m.br = 0; m.mr = 0; m.mtr = 0; m.mw = 0; m.as = 0; m.rw = 0; m.aop = 2'b00;
            end
        end
        @(negedge clk);
        check_ex(1'b0);
    endtask

    task automatic apply_reset_now();
        rst_n = 1'b0;
        #1;
        m = empty_slot();
        m_cnt = 0;
        chk("rst_stall", stall, 1'b0);
        check_ex(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        slot_t s, use_i, nop;
        logic  st;
        logic  hold;

        nop = empty_slot();
        m = empty_slot();
        m_cnt = 0;
        drive(nop);
        flush = 1'b0;
        apply_reset_now();
        @(negedge clk);
        rst_n = 1'b1;

        // add x3,x1,x2
        s = rtype(5'd3, 5'd1, 5'd2);
        step(s, 1'b0, st);
        chk("add_valid", ex_valid, 1'b1);
        chk("add_rw",    ex_regwrite, 1'b1);
        chk("add_aluop", ex_aluop, 2'b10);
        chk("add_rd",    ex_rd, 5'd3);
        step(nop, 1'b0, st);

        // lw x5,0(x1); add x6,x5,x2
        step(load(5'd5, 5'd1), 1'b0, st);
        use_i = rtype(5'd6, 5'd5, 5'd2);
        step(use_i, 1'b0, st);
        chk("lu_stall_seen", st, 1'b1);
        chk("lu_cnt", bubble_cnt, 16'd1);
        chk("lu_bubble_valid", ex_valid, 1'b0);
        step(use_i, 1'b0, st);
        chk("lu_add_rd", ex_rd, 5'd6);
        chk("lu_add_valid", ex_valid, 1'b1);

        // lw x0 never stalls
        step(load(5'd0, 5'd1), 1'b0, st);
        step(rtype(5'd6, 5'd0, 5'd2), 1'b0, st);
        chk("x0_cnt", bubble_cnt, 16'd1);

        // load-use coincident with flush
        step(load(5'd7, 5'd1), 1'b0, st);
        step(rtype(5'd8, 5'd7, 5'd7), 1'b1, st);
        chk("flush_cnt", bubble_cnt, 16'd1);

        // sw x2,4(x1) flushed, then not
        step(store(5'd1, 5'd2, 32'd4), 1'b1, st);
        chk("sw_fl_mw", ex_memwrite, 1'b0);
        step(store(5'd1, 5'd2, 32'd4), 1'b0, st);
        chk("sw_mw", ex_memwrite, 1'b1);
        chk("sw_as", ex_alusrc, 1'b1);

        // saturation from 0xFFFE
        force dut.r_bubble_cnt = 16'hFFFE;
        m_cnt = 32'hFFFE;
        step(nop, 1'b0, st);
        release dut.r_bubble_cnt;
        step(nop, 1'b0, st);
        for (int i = 0; i < 3; i++) begin
            step(load(5'd9, 5'd1), 1'b0, st);
            use_i = rtype(5'd10, 5'd2, 5'd9);
            step(use_i, 1'b0, st);
            step(use_i, 1'b0, st);
        end
        chk("sat_cnt", bubble_cnt, 16'hFFFF);

        // asynchronous reset while a stall is pending
        step(load(5'd11, 5'd1), 1'b0, st);
        use_i = rtype(5'd12, 5'd11, 5'd3);
        drive(use_i);
        #1;
        chk("pre_rst_stall", stall, 1'b1);
        apply_reset_now();
        @(negedge clk);
        rst_n = 1'b1;
        step(use_i, 1'b0, st);

        // randomized traffic; upstream holds ID while stalled
        hold = 1'b0;
        s = nop;
        for (int i = 0; i < 600; i++) begin
            if (!hold) s = rand_slot();
            step(s, ($urandom_range(0, 9) == 0), st);
            hold = st;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage RV32I core; sits directly downstream of the decode-stage control unit.
- Registers decoded control (branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop) together with the ID datapath operands.
- Detects load-use hazards against the instruction currently in EX, stalls PC and IF/ID, and inserts a bubble. Squashes on a taken-branch flush.
- Keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width (PC, register data, immediate).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_funct3  in  3  inst[14:12].
- id_funct7b5  in  1  inst[30].
- id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1  decoded control.
- id_aluop  in  2  decoded ALU op class.
- flush  in  1  taken branch resolved downstream; squash ID and EX-entry.
- stall  out  1  combinational; hold PC and IF/ID.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered copies.
- ex_funct3  out  3  registered copy.
- ex_funct7b5  out  1  registered copy.
- ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1  registered control.
- ex_aluop  out  2  registered control.
- bubble_cnt  out  CNT_W  saturating count of hazard bubbles.

Behaviour:
- Reset (async on rst_n low; deassertion is synchronised externally):
  - All ex_* outputs are 0, ex_valid is 0, bubble_cnt is 0.
  - stall is 0 while in reset.
- Hazard (combinational): hz = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
- stall = hz & ~flush. Flush has priority because the stalled ID instruction is being discarded anyway.
- Per rising edge, in priority order:
  - flush = 1: load a bubble (ex_valid = 0; every control output = 0, aluop = 00). bubble_cnt unchanged.
  - else hz = 1: load a bubble. bubble_cnt increments, saturating at all-ones.
  - else: capture every id_* field into ex_*, with ex_valid = id_valid.
- Bubble rules:
  - Control outputs are forced to 0 whenever ex_valid is 0, including when id_valid = 0 is captured. This guarantees no memwrite/regwrite/branch side effects from invalid slots.
  - Datapath fields in a bubble may hold stale values but must be 0 after reset.
- Latency: one cycle from ID to EX for non-hazard instructions. A load-use pair gets exactly one bubble.
- On the cycle after the bubble, ex_memread = 0, so hz clears and the held ID instruction advances. There is no multi-cycle stall from a single load.
- x0 rule: a load to x0 never stalls.
- Back-to-back loads:
  - Load A then load B with B.rs1 = A.rd: one bubble.
  - If B is then followed by a use of B.rd: one more bubble.
- Reset mid-stall: all state clears immediately; the pending ID instruction is re-presented by upstream after reset.
- The block does not check opcode legality. It propagates control exactly as decoded.

Decomposition:
- Shared package/header holds:
  - ALUOP_LOAD_STORE = 2'b00, ALUOP_BRANCH = 2'b01, ALUOP_RTYPE = 2'b10.
  - Opcode[6:2] constants: R = 01100, LOAD = 00000, STORE = 01000, BRANCH = 11000.
  - A packed control-bundle width constant (8 bits).
- One natural sub-module: hazard_detect, a combinational hz/stall computation from ID indices and EX state.
- The pipeline register and counter stay in id_ex_stage.

Test Plan:
- R-type add x3,x1,x2 with id_valid = 1 and no flush -> next cycle:
  - ex_valid = 1, ex_regwrite = 1, ex_aluop = 10, ex_rd = 3.
  - Operands and PC are copied exactly; stall stays 0 throughout.
- lw x5,0(x1) then add x6,x5,x2 -> while the add is in ID:
  - stall = 1 for exactly one cycle.
  - EX receives a bubble (all control 0, ex_valid = 0), and bubble_cnt goes 0 -> 1.
  - The add reaches EX on the following cycle.
- lw x0,0(x1) then add x6,x0,x2 -> stall never asserts and bubble_cnt stays 0.
- Load-use hazard coincident with flush = 1 -> stall = 0, EX gets a bubble, bubble_cnt is unchanged.
- sw x2,4(x1) with flush = 1 -> ex_memwrite = 0 and ex_valid = 0 next cycle. With flush = 0 instead -> ex_memwrite = 1 and ex_alusrc = 1.
- Force bubble_cnt to 0xFFFE, then issue 3 load-use pairs -> bubble_cnt reads 0xFFFF and holds. Then assert rst_n = 0 mid-stall -> all outputs read 0 immediately, asynchronously, without waiting for a clock edge.
